bcd_3digit_serial_sub: RTL and testbench

//  Digit-serial BCD subtractor: the inverse operation of the team's 3-digit BCD CLA adder.

---
 rtl/bcd_3digit_serial_sub.sv | 115 +++++++++++
 tb/tb_bcd_3digit_serial_sub.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_3digit_serial_sub.sv
// Digit-serial BCD subtractor: D = A - B - Bin, one digit per clock, LSD first.
// Negative results are returned as the tens complement with Bout set.
module bcd_3digit_serial_sub #(
  parameter int unsigned N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] A,
  input  logic [4*N_DIGITS-1:0] B,
  input  logic                  Bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] D,
  output logic                  Bout,
  output logic                  err
);

  localparam int unsigned W    = 4 * N_DIGITS;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    d_q, d_d;
  logic            borrow_q, borrow_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic            any_bad;
  logic [3:0]      a_dig, b_dig, d_dig;
  logic [4:0]      diff;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  end

  // diff[4] is the sign: set when this digit needs a borrow from the next one.
  always_comb begin
    a_dig = a_q[4*int'(idx_q) +: 4];
    b_dig = b_q[4*int'(idx_q) +: 4];
    diff  = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow_q};
    d_dig = diff[4] ? (diff[3:0] + 4'd10) : diff[3:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    idx_d    = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          idx_d    = '0;
          d_d      = '0;
          err_d    = any_bad;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        d_d[4*int'(idx_q) +: 4] = d_dig;
        borrow_d                = diff[4];
        if (idx_q == IdxW'(N_DIGITS - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
    end
  end

  // Invalid digits force a zero result regardless of the arithmetic.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign D         = err_q ? '0 : d_q;
  assign Bout      = out_valid & ~err_q & borrow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_3digit_serial_sub.sv
// Bench for bcd_3digit_serial_sub: directed cases with literal results plus randomized
// traffic checked every cycle against an integer-arithmetic reference model.
module tb_bcd_3digit_serial_sub;

  localparam int N = 3;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         Bin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_ready, out_valid, Bout, err;
  logic [W-1:0] D;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         e;
    int           t0;
    bit           seen;
  } exp_t;

  exp_t exp_q[$];

  bcd_3digit_serial_sub #(.N_DIGITS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .Bout     (Bout),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer subtraction, tens complement when negative.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t r;
    int av = 0, bv = 0, p = 1, diff;
    r.e = 1'b0;
    for (int i = 0; i < N; i++) begin
      int da = int'(a[4*i +: 4]);
      int db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) r.e = 1'b1;
      av += da * p;
      bv += db * p;
      p  *= 10;
    end
    diff = av - bv - int'(bin);
    r.bo = (diff < 0);
    if (diff < 0) diff += p;
    r.d = '0;
    for (int i = 0; i < N; i++) begin
      r.d[4*i +: 4] = 4'(diff % 10);
      diff /= 10;
    end
    if (r.e) begin
      r.d  = '0;
      r.bo = 1'b0;
    end
    r.t0   = 0;
    r.seen = 1'b0;
    return r;
  endfunction

  // Monitor: tracks accepted operations and consumed results at each active edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e    = model(A, B, Bin);
        e.t0 = cyc;
        exp_q.push_back(e);
      end
    end
    cyc++;
  end

  // Compare: every cycle the result is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
      chk("result_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("D", 32'(D), 32'(exp_q[0].d));
        chk("Bout", 32'(Bout), 32'(exp_q[0].bo));
        chk("err", 32'(err), 32'(exp_q[0].e));
        if (!exp_q[0].seen) begin
          chk("latency", 32'(cyc - exp_q[0].t0), 32'(N + 1));
          exp_q[0].seen = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n = 0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Bin      = bin;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    A        = W'($urandom);
    B        = W'($urandom);
    Bin      = 1'($urandom);
  endtask

  // Waits for the result with out_ready high, checks literals, and checks the return to idle.
  task automatic expect_out(input logic [W-1:0] d, input logic bo, input logic e);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("out_valid_timeout", 32'd0, 32'd1);
    chk("lit_D", 32'(D), 32'(d));
    chk("lit_Bout", 32'(Bout), 32'(bo));
    chk("lit_err", 32'(err), 32'(e));
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    int k;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 11) == 0) begin
      k = $urandom_range(0, N - 1);
      v[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_Bout", 32'(Bout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(12'h345, 12'h123, 1'b0);  expect_out(12'h222, 1'b0, 1'b0);
    send(12'h100, 12'h001, 1'b0);  expect_out(12'h099, 1'b0, 1'b0);
    send(12'h000, 12'h001, 1'b0);  expect_out(12'h999, 1'b1, 1'b0);
    send(12'h999, 12'h999, 1'b1);  expect_out(12'h999, 1'b1, 1'b0);
    send(12'h0A5, 12'h001, 1'b0);  expect_out(12'h000, 1'b0, 1'b1);
    send(12'h500, 12'h499, 1'b1);  expect_out(12'h000, 1'b0, 1'b0);

    // Backpressure holds the result.
    out_ready = 1'b0;
    send(12'h345, 12'h123, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_D", 32'(D), 32'h222);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", 32'(in_ready), 32'd1);

    // Reset in the second CALC cycle discards the operation.
    send(12'h345, 12'h123, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_D", 32'(D), 32'd0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 32'd0);
    end
    send(12'h100, 12'h001, 1'b0);  expect_out(12'h099, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and gaps.
    repeat (200) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rand_op(), rand_op(), 1'($urandom));
      n = 0;
      do begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 2) != 0);
        n++;
      end while (!(out_valid && out_ready) && n < 100);
      if (n == 100) chk("rand_result_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
